// File: rtl/gb_timer_if.sv
// gb_timer_if - CPU-side bus bundle for the DMG timer peripheral.
//
// Signals:
//   mem_strobe    one-clock pulse on the last T-cycle of an M-cycle (write commit)
//   mem_addr      16-bit CPU address
//   mem_enable    bus access enable
//   mem_write     bus write enable
//   mem_data_in   write data from the CPU
//   mem_data_out  read data back to the CPU (8'hFF when not hit)
//   mem_hit       responder claims the current address
//
// Modports: master = CPU side, slave = timer side.
interface gb_timer_if;
    logic        mem_strobe;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_hit;

    modport master (
        output mem_strobe, mem_addr, mem_enable, mem_write, mem_data_in,
        input  mem_data_out, mem_hit
    );

    modport slave (
        input  mem_strobe, mem_addr, mem_enable, mem_write, mem_data_in,
        output mem_data_out, mem_hit
    );
endinterface

// File: rtl/gb_timer.sv
// gb_timer - memory-mapped DMG timer (DIV, TIMA, TMA, TAC at BASE_ADDR..+3).
//
// Ports:
//   clk        system clock, one T-cycle per clock
//   reset      asynchronous active-high reset
//   bus        gb_timer_if.slave: CPU address/enable/write/data, read data, hit
//   irq_timer  one-clock pulse when TIMA is reloaded from TMA after an overflow
//
// Build option:
//   TIMER_GLITCH_EN  when defined, the falling-edge detector watches tick_sig
//                    directly, so DIV clears and TAC writes that drop tick_sig
//                    produce the spurious increments real hardware shows.
//                    When undefined, only natural counter transitions count.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic       clk,
    input  logic       reset,
    gb_timer_if.slave  bus,
    output logic       irq_timer
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_OVERFLOW = 2'd1,
        ST_RELOAD   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [15:0] sys_cnt_reg;
    logic [7:0]  tima_reg;
    logic [7:0]  tma_reg;
    logic [2:0]  tac_reg;
    logic        irq_reg;
    logic        inc;

    // Address decode: offset from BASE_ADDR, hit when it lands in 0..3.
    logic [15:0] addr_off;
    logic        wr_commit;
    logic        div_wr, tima_wr, tma_wr, tac_wr;

    assign addr_off    = bus.mem_addr - BASE_ADDR;
    assign bus.mem_hit = bus.mem_enable && (addr_off[15:2] == 14'd0);
    assign wr_commit   = bus.mem_strobe && bus.mem_hit && bus.mem_write;
    assign div_wr      = wr_commit && (addr_off[1:0] == 2'd0);
    assign tima_wr     = wr_commit && (addr_off[1:0] == 2'd1);
    assign tma_wr      = wr_commit && (addr_off[1:0] == 2'd2);
    assign tac_wr      = wr_commit && (addr_off[1:0] == 2'd3);

    always_comb begin
        bus.mem_data_out = 8'hFF;
        if (bus.mem_hit) begin
            case (addr_off[1:0])
                2'd0:    bus.mem_data_out = sys_cnt_reg[15:8];
                2'd1:    bus.mem_data_out = tima_reg;
                2'd2:    bus.mem_data_out = tma_reg;
                default: bus.mem_data_out = {5'b11111, tac_reg};
            endcase
        end
    end

    // Tick source selection.
    logic [3:0]  sel_idx;
    logic [15:0] sys_cnt_plus;
    logic        tick_sig;

    always_comb begin
        case (tac_reg[1:0])
            2'b00:   sel_idx = 4'd9;
            2'b01:   sel_idx = 4'd3;
            2'b10:   sel_idx = 4'd5;
            default: sel_idx = 4'd7;
        endcase
    end

    assign sys_cnt_plus = sys_cnt_reg + 16'd1;
    assign tick_sig     = tac_reg[2] & sys_cnt_reg[sel_idx];

    // Free-running divider; a DIV write wins over the natural increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_cnt_reg <= 16'd0;
            tac_reg     <= 3'd0;
            tma_reg     <= 8'd0;
        end else begin
            sys_cnt_reg <= div_wr ? 16'd0 : sys_cnt_plus;
            if (tac_wr)
                tac_reg <= bus.mem_data_in[2:0];
            if (tma_wr)
                tma_reg <= bus.mem_data_in;
        end
    end

`ifdef TIMER_GLITCH_EN
    // Edge detector on tick_sig itself: any 1->0 drop counts, whatever caused it.
    logic tick_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_prev_reg <= 1'b0;
        else
            tick_prev_reg <= tick_sig;
    end

    assign inc = tick_prev_reg & ~tick_sig;
`else
    // Only a natural +1 transition that drops the selected bit is remembered;
    // DIV clears and TAC rewrites never register as a fall.
    logic fall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fall_reg <= 1'b0;
        else
            fall_reg <= tick_sig & ~sys_cnt_plus[sel_idx] & ~div_wr & ~tac_wr;
    end

    assign inc = fall_reg;
`endif

    // TIMA and its overflow/reload sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_NORMAL;
            cnt_reg   <= 2'd0;
            tima_reg  <= 8'd0;
            irq_reg   <= 1'b0;
        end else begin
            irq_reg <= 1'b0;
            case (state_reg)
                ST_NORMAL: begin
                    if (tima_wr) begin
                        tima_reg <= bus.mem_data_in;
                    end else if (inc) begin
                        tima_reg <= tima_reg + 8'd1;
                        if (tima_reg == 8'hFF) begin
                            state_reg <= ST_OVERFLOW;
                            cnt_reg   <= 2'd0;
                        end
                    end
                end
                ST_OVERFLOW: begin
                    if (tima_wr) begin
                        // CPU write cancels the pending reload and interrupt.
                        tima_reg  <= bus.mem_data_in;
                        state_reg <= ST_NORMAL;
                    end else if (cnt_reg == 2'd3) begin
                        tima_reg  <= tma_wr ? bus.mem_data_in : tma_reg;
                        irq_reg   <= 1'b1;
                        state_reg <= ST_RELOAD;
                        cnt_reg   <= 2'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                        if (inc)
                            tima_reg <= tima_reg + 8'd1;
                    end
                end
                ST_RELOAD: begin
                    // TIMA writes are dropped; TMA writes pass straight through.
                    if (tma_wr)
                        tima_reg <= bus.mem_data_in;
                    else if (inc)
                        tima_reg <= tima_reg + 8'd1;
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3)
                        state_reg <= ST_NORMAL;
                end
                default: begin
                    state_reg <= ST_NORMAL;
                    cnt_reg   <= 2'd0;
                end
            endcase
        end
    end

    assign irq_timer = irq_reg;

endmodule

// File: tb/tb_gb_timer.sv
module tb_gb_timer;

    logic clk;
    logic reset;
    logic irq_timer;
    int   vectors;
    int   miscompares;

    gb_timer_if bus_if ();

    gb_timer #(.BASE_ADDR(16'hFF04)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .irq_timer (irq_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic bus_idle();
        bus_if.mem_strobe  = 1'b0;
        bus_if.mem_enable  = 1'b0;
        bus_if.mem_write   = 1'b0;
        bus_if.mem_addr    = 16'h0000;
        bus_if.mem_data_in = 8'h00;
    endtask

    // Combinational read between clock edges.
    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_if.mem_addr   = a;
        bus_if.mem_enable = 1'b1;
        bus_if.mem_write  = 1'b0;
        #1;
        d = bus_if.mem_data_out;
        bus_if.mem_enable = 1'b0;
    endtask

    // Write that commits on the next rising edge; returns at edge+1.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.mem_addr    = a;
        bus_if.mem_data_in = d;
        bus_if.mem_enable  = 1'b1;
        bus_if.mem_write   = 1'b1;
        bus_if.mem_strobe  = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Program TAC=05 TMA=80 TIMA=FE and run until TIMA reads FF.
    task automatic run_to_ff(output bit ok);
        logic [7:0] d;
        ok = 1'b0;
        bus_write(16'hFF07, 8'h05);
        bus_write(16'hFF06, 8'h80);
        bus_write(16'hFF05, 8'hFE);
        for (int i = 0; i < 64; i++) begin
            bus_read(16'hFF05, d);
            if (d == 8'hFF) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b expected 0", irq_timer);
        end
        vectors++;
        if (bus_if.mem_hit !== 1'b0 || bus_if.mem_data_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_idle_bus: hit=%b data=%h expected hit=0 data=ff",
                     bus_if.mem_hit, bus_if.mem_data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_read(16'hFF04, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL reset_div: got %h expected 00", d); end
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL reset_tima: got %h expected 00", d); end
        bus_read(16'hFF06, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL reset_tma: got %h expected 00", d); end
        bus_read(16'hFF07, d);
        vectors++;
        if (d !== 8'hF8) begin miscompares++; $display("FAIL reset_tac: got %h expected f8", d); end
        $display("test_reset: registers read after reset");
    endtask

    task automatic test_div();
        logic [7:0] d;
        // sys_cnt is 0 here; 1280 edges later it is 16'h0500.
        repeat (1280) @(posedge clk);
        #1;
        bus_read(16'hFF04, d);
        vectors++;
        if (d !== 8'h05) begin miscompares++; $display("FAIL div_1280: got %h expected 05", d); end
        bus_write(16'hFF04, 8'hAA);
        bus_read(16'hFF04, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL div_clear: got %h expected 00", d); end
        bus_write(16'hFF07, 8'hFA);
        bus_read(16'hFF07, d);
        vectors++;
        if (d !== 8'hFA) begin miscompares++; $display("FAIL tac_rw: got %h expected fa", d); end
        bus_write(16'hFF06, 8'h5A);
        bus_read(16'hFF06, d);
        vectors++;
        if (d !== 8'h5A) begin miscompares++; $display("FAIL tma_rw: got %h expected 5a", d); end
        $display("test_div: DIV=05 after 1280 clks, clear, TAC/TMA readback");
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        bit ok;
        int n;
        apply_reset();
        run_to_ff(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ovf_reach_ff: timeout got 0 expected 1"); end
        n = 0;
        d = 8'hFF;
        while (d == 8'hFF && n < 40) begin
            step();
            n++;
            bus_read(16'hFF05, d);
        end
        vectors++;
        if (n != 16 || d !== 8'h00) begin
            miscompares++;
            $display("FAIL ovf_tick_period: clks=%0d tima=%h expected clks=16 tima=00", n, d);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            bus_read(16'hFF05, d);
            vectors++;
            if (d !== 8'h00 || irq_timer !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf_window%0d: tima=%h irq=%b expected tima=00 irq=0", i, d, irq_timer);
            end
        end
        step();
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h80 || irq_timer !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_reload: tima=%h irq=%b expected tima=80 irq=1", d, irq_timer);
        end
        step();
        vectors++;
        if (irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_irq_width: irq=%b expected 0", irq_timer);
        end
        $display("test_overflow: FE->FF->00 x4 -> 80 with single irq");
    endtask

    task automatic test_cancel();
        logic [7:0] d;
        bit ok;
        bit irq_seen;
        apply_reset();
        run_to_ff(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL cancel_reach_ff: timeout got 0 expected 1"); end
        d = 8'hFF;
        for (int i = 0; i < 40 && d == 8'hFF; i++) begin
            step();
            bus_read(16'hFF05, d);
        end
        // One clock into the 00 window; the write commits on the next edge.
        bus_write(16'hFF05, 8'h10);
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h10) begin miscompares++; $display("FAIL cancel_write: got %h expected 10", d); end
        irq_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (irq_timer) irq_seen = 1'b1;
        end
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h10 || irq_seen) begin
            miscompares++;
            $display("FAIL cancel_no_reload: tima=%h irq_seen=%b expected tima=10 irq_seen=0", d, irq_seen);
        end
        $display("test_cancel: TIMA write in overflow window cancels reload");
    endtask

    task automatic test_reload_writes();
        logic [7:0] d;
        bit ok;
        apply_reset();
        run_to_ff(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL reload_reach_ff: timeout got 0 expected 1"); end
        for (int i = 0; i < 40 && !irq_timer; i++) step();
        vectors++;
        if (irq_timer !== 1'b1) begin miscompares++; $display("FAIL reload_irq: got %b expected 1", irq_timer); end
        bus_write(16'hFF05, 8'h33);
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h80) begin miscompares++; $display("FAIL reload_tima_ignored: got %h expected 80", d); end
        bus_write(16'hFF06, 8'h44);
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h44) begin miscompares++; $display("FAIL reload_tma_to_tima: got %h expected 44", d); end
        bus_read(16'hFF06, d);
        vectors++;
        if (d !== 8'h44) begin miscompares++; $display("FAIL reload_tma: got %h expected 44", d); end
        $display("test_reload_writes: TIMA write ignored, TMA write copied");
    endtask

    task automatic test_div_glitch();
        logic [7:0] d;
        logic [7:0] t;
        logic [7:0] exp_tima;
        bit found;
        apply_reset();
        bus_write(16'hFF07, 8'h05);
        bus_write(16'hFF05, 8'h20);
        found = 1'b0;
        t = 8'h20;
        for (int i = 0; i < 40; i++) begin
            step();
            bus_read(16'hFF05, d);
            if (d != 8'h20) begin
                found = 1'b1;
                t = d;
                break;
            end
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL glitch_sync: timeout got 0 expected 1"); end
        // Counter low nibble is 1 now; after 8 more edges it is 9 (bit 3 set).
        repeat (8) step();
        bus_write(16'hFF04, 8'h00);
        repeat (2) step();
`ifdef TIMER_GLITCH_EN
        exp_tima = t + 8'd1;
`else
        exp_tima = t;
`endif
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== exp_tima) begin
            miscompares++;
            $display("FAIL glitch_div_clear: got %h expected %h", d, exp_tima);
        end
        bus_read(16'hFF04, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL glitch_div_value: got %h expected 00", d); end
        $display("test_div_glitch: DIV clear with bit3 high, TIMA=%h", exp_tima);
    endtask

    task automatic test_reset_in_overflow();
        logic [7:0] d;
        bit ok;
        bit irq_seen;
        apply_reset();
        run_to_ff(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rst_ovf_reach_ff: timeout got 0 expected 1"); end
        d = 8'hFF;
        for (int i = 0; i < 40 && d == 8'hFF; i++) begin
            step();
            bus_read(16'hFF05, d);
        end
        repeat (2) step();
        reset = 1'b1;
        #1;
        irq_seen = irq_timer;
        bus_read(16'hFF04, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL rst_ovf_div: got %h expected 00", d); end
        bus_read(16'hFF05, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL rst_ovf_tima: got %h expected 00", d); end
        bus_read(16'hFF06, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL rst_ovf_tma: got %h expected 00", d); end
        bus_read(16'hFF07, d);
        vectors++;
        if (d !== 8'hF8) begin miscompares++; $display("FAIL rst_ovf_tac: got %h expected f8", d); end
        repeat (3) begin step(); if (irq_timer) irq_seen = 1'b1; end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin step(); if (irq_timer) irq_seen = 1'b1; end
        vectors++;
        if (irq_seen) begin miscompares++; $display("FAIL rst_ovf_irq: got 1 expected 0"); end
        bus_if.mem_addr   = 16'hFF08;
        bus_if.mem_enable = 1'b1;
        #1;
        vectors++;
        if (bus_if.mem_hit !== 1'b0 || bus_if.mem_data_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL miss_ff08: hit=%b data=%h expected hit=0 data=ff",
                     bus_if.mem_hit, bus_if.mem_data_out);
        end
        bus_if.mem_addr = 16'hFF05;
        #1;
        vectors++;
        if (bus_if.mem_hit !== 1'b1) begin miscompares++; $display("FAIL hit_ff05: got %b expected 1", bus_if.mem_hit); end
        bus_if.mem_enable = 1'b0;
        #1;
        vectors++;
        if (bus_if.mem_hit !== 1'b0) begin miscompares++; $display("FAIL hit_disabled: got %b expected 0", bus_if.mem_hit); end
        bus_idle();
        $display("test_reset_in_overflow: reset clears state, no irq; FF08 misses");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus_idle();
        test_reset();
        test_div();
        test_overflow();
        test_cancel();
        test_reload_writes();
        test_div_glitch();
        test_reset_in_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
